// File: rtl/calc_sequencer.sv
// Control sequencer for the serial binary calculator: deserialises command
// fields, then runs the ALU/store handshake or reads and shifts out a word.
module calc_sequencer #(
  parameter int DATA_W      = 8,
  parameter int OP_W        = 4,
  parameter int ADDR_W      = 2,
  parameter int ALU_TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Active,
  input  logic              Mode,
  input  logic              InputKey,
  input  logic              ValidCmd,
  input  logic [DATA_W-1:0] AluResult,
  input  logic [3:0]        AluFlags,
  input  logic              AluDone,
  input  logic [DATA_W+3:0] MemRdData,
  output logic [DATA_W-1:0] OpA,
  output logic [DATA_W-1:0] OpB,
  output logic [OP_W-1:0]   OpSel,
  output logic              AluStart,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemWrEn,
  output logic [DATA_W+3:0] MemWrData,
  output logic              MemRdEn,
  output logic              OutBit,
  output logic              OutValid,
  output logic              Busy,
  output logic              Error
);

  localparam int MEM_W = DATA_W + 4;
  localparam int CNT_W = $clog2(MEM_W + 1);
  localparam int TMO_W = $clog2(ALU_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] OP_LAST   = CNT_W'(OP_W - 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(MEM_W - 1);
  localparam logic [TMO_W-1:0] TMO_MAX   = TMO_W'(ALU_TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_LOAD_OP,
    S_LOAD_ADDR,
    S_EXEC,
    S_WRITE,
    S_RD_ADDR,
    S_READ,
    S_SHIFT_OUT,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [OP_W-1:0]   opsel_q, opsel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              rdph_q, rdph_d;
  logic [MEM_W-1:0]  wrdata_q, wrdata_d;
  logic [MEM_W-1:0]  sh_q, sh_d;

  logic bit_in;
  logic field_done;

  // A bit is consumed only while the session is still active.
  always_comb begin
    bit_in     = Active && ValidCmd;
    field_done = 1'b0;
    case (state_q)
      S_LOAD_A, S_LOAD_B: field_done = bit_in && (bitcnt_q == DATA_LAST);
      S_LOAD_OP:          field_done = bit_in && (bitcnt_q == OP_LAST);
      S_LOAD_ADDR,
      S_RD_ADDR:          field_done = bit_in && (bitcnt_q == ADDR_LAST);
      default:            field_done = 1'b0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (Active) state_d = Mode ? S_RD_ADDR : S_LOAD_A;
      S_LOAD_A:    if (!Active) state_d = S_IDLE; else if (field_done) state_d = S_LOAD_B;
      S_LOAD_B:    if (!Active) state_d = S_IDLE; else if (field_done) state_d = S_LOAD_OP;
      S_LOAD_OP:   if (!Active) state_d = S_IDLE; else if (field_done) state_d = S_LOAD_ADDR;
      S_LOAD_ADDR: if (!Active) state_d = S_IDLE; else if (field_done) state_d = S_EXEC;
      S_EXEC: begin
        if (AluDone)                state_d = S_WRITE;
        else if (tmo_q == TMO_MAX)  state_d = S_IDLE;
      end
      S_WRITE:     state_d = S_DONE;
      S_RD_ADDR:   if (!Active) state_d = S_IDLE; else if (field_done) state_d = S_READ;
      S_READ:      if (rdph_q) state_d = S_SHIFT_OUT;
      S_SHIFT_OUT: if (bitcnt_q == SHIFT_LAST) state_d = S_DONE;
      S_DONE:      if (!Active) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    opa_d    = opa_q;
    opb_d    = opb_q;
    opsel_d  = opsel_q;
    addr_d   = addr_q;
    bitcnt_d = bitcnt_q;
    tmo_d    = tmo_q;
    rdph_d   = rdph_q;
    wrdata_d = wrdata_q;
    sh_d     = sh_q;

    case (state_q)
      S_IDLE: begin
        bitcnt_d = '0;
        tmo_d    = '0;
        rdph_d   = 1'b0;
      end
      S_LOAD_A, S_LOAD_B, S_LOAD_OP, S_LOAD_ADDR, S_RD_ADDR: begin
        if (!Active) begin
          bitcnt_d = '0;
        end else if (ValidCmd) begin
          bitcnt_d = field_done ? '0 : bitcnt_q + CNT_W'(1);
          case (state_q)
            S_LOAD_A:  opa_d   = DATA_W'({opa_q, InputKey});
            S_LOAD_B:  opb_d   = DATA_W'({opb_q, InputKey});
            S_LOAD_OP: opsel_d = OP_W'({opsel_q, InputKey});
            default:   addr_d  = ADDR_W'({addr_q, InputKey});
          endcase
        end
      end
      S_EXEC: begin
        if (tmo_q != TMO_MAX) tmo_d = tmo_q + TMO_W'(1);
        if (AluDone) wrdata_d = {AluFlags, AluResult};
      end
      // Read data arrives one cycle after the strobe, so READ spans two cycles.
      S_READ: begin
        rdph_d = 1'b1;
        if (rdph_q) begin
          sh_d     = MemRdData;
          bitcnt_d = '0;
        end
      end
      S_SHIFT_OUT: begin
        sh_d     = MEM_W'({sh_q, 1'b0});
        bitcnt_d = bitcnt_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      opa_q    <= '0;
      opb_q    <= '0;
      opsel_q  <= '0;
      addr_q   <= '0;
      bitcnt_q <= '0;
      tmo_q    <= '0;
      rdph_q   <= 1'b0;
      wrdata_q <= '0;
      sh_q     <= '0;
    end else begin
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      opsel_q  <= opsel_d;
      addr_q   <= addr_d;
      bitcnt_q <= bitcnt_d;
      tmo_q    <= tmo_d;
      rdph_q   <= rdph_d;
      wrdata_q <= wrdata_d;
      sh_q     <= sh_d;
    end
  end

  always_comb begin
    OpA       = opa_q;
    OpB       = opb_q;
    OpSel     = opsel_q;
    MemAddr   = addr_q;
    MemWrData = wrdata_q;
    AluStart  = (state_q == S_EXEC) && (tmo_q == '0);
    MemWrEn   = (state_q == S_WRITE);
    MemRdEn   = (state_q == S_READ) && !rdph_q;
    OutValid  = (state_q == S_SHIFT_OUT);
    OutBit    = (state_q == S_SHIFT_OUT) && sh_q[MEM_W-1];
    Busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    Error     = (state_q == S_EXEC) && !AluDone && (tmo_q == TMO_MAX);
  end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Control sequencer for the serial binary calculator. It sits behind the key decoder: once the decoder raises Active, this block deserialises the command fields from InputKey. It then either runs the ALU and writes the result to the result memory (Mode=0), or reads a memory word and shifts it out serially (Mode=1). It owns the ALU start/done handshake and all memory strobes.

Parameters:
DATA_W, 8, operand and ALU result width
OP_W, 4, ALU opcode width
ADDR_W, 2, result memory address width
ALU_TIMEOUT, 15, max cycles to wait for AluDone after AluStart

Ports:
Clk  in  1  clock, all state updates on posedge
Reset  in  1  synchronous, active-high
Active  in  1  session enable from key decoder
Mode  in  1  0 = compute-and-store, 1 = read-and-shift-out
InputKey  in  1  serial data bit
ValidCmd  in  1  qualifies InputKey; one bit consumed per cycle with ValidCmd=1
AluResult  in  DATA_W  ALU result
AluFlags  in  4  ALU flags
AluDone  in  1  ALU completion strobe
MemRdData  in  DATA_W+4  memory read data, valid the cycle after MemRdEn
OpA  out  DATA_W  operand A to ALU
OpB  out  DATA_W  operand B to ALU
OpSel  out  OP_W  ALU opcode
AluStart  out  1  one-cycle start pulse
MemAddr  out  ADDR_W  memory address
MemWrEn  out  1  one-cycle write strobe
MemWrData  out  DATA_W+4  {AluFlags, AluResult}
MemRdEn  out  1  one-cycle read strobe
OutBit  out  1  serial output bit
OutValid  out  1  qualifies OutBit
Busy  out  1  high in every state except IDLE and DONE
Error  out  1  one-cycle pulse on ALU timeout

Behaviour:
- Reset: all outputs 0 and state IDLE on the first posedge with Reset=1. Reset wins over every other event, in any state.
- Serial fields are MSB first. A bit is shifted in only on cycles with ValidCmd=1. Gaps with ValidCmd=0 hold the field and bit counter unchanged.
- States: IDLE, LOAD_A, LOAD_B, LOAD_OP, LOAD_ADDR, EXEC, WRITE, RD_ADDR, READ, SHIFT_OUT, DONE.
- IDLE: when Active=1, latch Mode. Go to LOAD_A if Mode=0, or RD_ADDR if Mode=1.
- LOAD_A / LOAD_B / LOAD_OP / LOAD_ADDR: each consumes DATA_W / DATA_W / OP_W / ADDR_W valid bits, then advances. OpA, OpB, OpSel and MemAddr update as their bits arrive and hold until the next session.
- After the last ADDR bit: enter EXEC; AluStart=1 for exactly the first EXEC cycle.
- EXEC: wait for AluDone.
  - AluDone=1 → WRITE.
  - If ALU_TIMEOUT cycles after AluStart pass without AluDone → Error=1 for one cycle, then IDLE, with no write.
- WRITE: single cycle. MemWrEn=1 and MemWrData={AluFlags,AluResult}, values sampled on the AluDone cycle. Then DONE.
- RD_ADDR: consumes ADDR_W valid bits, then READ.
- READ: MemRdEn=1 for one cycle; capture MemRdData on the following cycle into the shift register. Then SHIFT_OUT.
- SHIFT_OUT: DATA_W+4 consecutive cycles, MSB first, with OutValid=1 and OutBit = current MSB. Independent of ValidCmd. Then DONE.
- DONE: hold until Active=0, then IDLE. This means one session per Active assertion; there is no retrigger while Active stays high.
- Abort: Active=0 during any LOAD_*/RD_ADDR state → IDLE next cycle. No AluStart, MemWrEn or MemRdEn is issued.
- Active=0 during EXEC, WRITE, READ or SHIFT_OUT is ignored: the operation completes, then goes to DONE, then IDLE.
- AluDone outside EXEC is ignored.

Test Plan:
- Mode=0; A=0x0F, B=0x01, Op=0x0, Addr=2'b10, 22 contiguous valid bits; ALU model returns AluResult=0x10, AluFlags=0x0 two cycles after AluStart. Required: AluStart pulses on the cycle after the last bit; MemWrEn for one cycle with MemAddr=2, MemWrData=12'h010; then DONE, and IDLE after Active falls.
- Mode=1; Addr=2'b01; memory model returns 12'hA5C. Required: MemRdEn for one cycle with MemAddr=1; OutValid high for exactly 12 cycles; OutBit stream 1010_0101_1100.
- Mode=0 with ValidCmd=0 gaps of 1–3 cycles between bits. Required: OpA/OpB/OpSel/MemAddr identical to the contiguous case, and identical write data.
- Active dropped after 3 bits of operand B. Required: IDLE next cycle; AluStart, MemWrEn and MemRdEn never assert; a new session then starts cleanly from LOAD_A.
- AluDone held 0 after AluStart. Required: Error pulses for one cycle 15 cycles after AluStart; no MemWrEn; state returns to IDLE.
- Reset asserted mid-SHIFT_OUT (bit 5). Required: OutValid=0 and all outputs 0 on the next cycle; Busy=0.
